// File: rtl/shift_rotate_seq.sv
// Multi-cycle shift/rotate sequencer: moves the working register by at most
// MAX_STEP bit positions per RUN cycle and publishes the result with a done pulse.
module shift_rotate_seq #(
   parameter int WIDTH    = 32,
   parameter int MAX_STEP = 4
) (
   input  logic              clock_i,
   input  logic              clear_i,
   input  logic              start_i,
   input  logic [2:0]        op_i,
   input  logic [WIDTH-1:0]  operand_i,
   input  logic [WIDTH-1:0]  amount_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [WIDTH-1:0]  result_o
);

   localparam logic [2:0] OP_SHR  = 3'b000;
   localparam logic [2:0] OP_SHRA = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_ROR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;

   localparam logic [5:0] STEP  = 6'(MAX_STEP);
   localparam logic [5:0] FULL  = 6'd32;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [31:0]       work_q, work_d;
   logic [5:0]        rem_q, rem_d;
   logic [31:0]       result_q, result_d;
   logic              done_q, done_d;

   logic [5:0]        n_eff;
   logic [5:0]        step_s;
   logic [31:0]       shifted;

   // One partial move of s positions; s never exceeds MAX_STEP, so the
   // rotate complement (32 - s) never reaches a full-width shift for s > 0.
   function automatic logic [31:0] step_shift(input logic [2:0] op,
                                               input logic [31:0] v,
                                               input logic [5:0] s);
      logic signed [31:0] sv;
      sv = $signed(v);
      case (op)
         OP_SHR:  return v >> s;
         OP_SHRA: return 32'(sv >>> s);
         OP_SHL:  return v << s;
         OP_ROR:  return (s == 6'd0) ? v : ((v >> s) | (v << (FULL - s)));
         OP_ROL:  return (s == 6'd0) ? v : ((v << s) | (v >> (FULL - s)));
         default: return v;
      endcase
   endfunction

   always_comb begin
      n_eff = 6'd0;
      case (op_i)
         OP_SHR, OP_SHRA, OP_SHL: n_eff = (|amount_i[31:5]) ? FULL : {1'b0, amount_i[4:0]};
         OP_ROR, OP_ROL:          n_eff = {1'b0, amount_i[4:0]};
         default:                 n_eff = 6'd0;
      endcase
   end

   assign step_s  = (rem_q > STEP) ? STEP : rem_q;
   assign shifted = step_shift(op_q, work_q, step_s);

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      work_d   = work_q;
      rem_d    = rem_q;
      result_d = result_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               op_d    = op_i;
               work_d  = operand_i;
               rem_d   = n_eff;
               state_d = RUN;
            end
         end
         RUN: begin
            work_d = shifted;
            rem_d  = rem_q - step_s;
            if (step_s == rem_q) begin
               result_d = shifted;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge clear_i) begin
      if (!clear_i) begin
         state_q  <= IDLE;
         op_q     <= 3'b000;
         work_q   <= 32'd0;
         rem_q    <= 6'd0;
         result_q <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         work_q   <= work_d;
         rem_q    <= rem_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign busy_o   = (state_q == RUN);
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Bench for shift_rotate_seq: directed vector table, hand sequences for the
// handshake corners, and random operations against a one-shot reference model.
module tb_shift_rotate_seq;

   logic        clock_i = 1'b0;
   logic        clear_i;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] operand_i;
   logic [31:0] amount_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   int errors = 0;
   int checks = 0;

   shift_rotate_seq #(.WIDTH(32), .MAX_STEP(4)) dut (
      .clock_i  (clock_i),
      .clear_i  (clear_i),
      .start_i  (start_i),
      .op_i     (op_i),
      .operand_i(operand_i),
      .amount_i (amount_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   always #5 clock_i = ~clock_i;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] opd;
      logic [31:0] amt;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: effective count, then the whole move done at once on a doubled word.
   function automatic int eff_n(input logic [2:0] op, input logic [31:0] amt);
      if (op == 3'd3 || op == 3'd4) return int'(amt % 32);
      if (op <= 3'd2) return (amt > 32) ? 32 : int'(amt);
      return 0;
   endfunction

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] v,
                                         input logic [31:0] amt);
      int n;
      logic [63:0] dbl;
      n   = eff_n(op, amt);
      dbl = {v, v};
      case (op)
         3'd0: return (n >= 32) ? 32'd0 : v / (32'd1 << n);
         3'd1: return (n >= 32) ? {32{v[31]}} : (v / (32'd1 << n)) | (v[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
         3'd2: return (n >= 32) ? 32'd0 : v * (32'd1 << n);
         3'd3: begin dbl = dbl >> n; return dbl[31:0];  end
         3'd4: begin dbl = dbl << n; return dbl[63:32]; end
         default: return v;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] op, input logic [31:0] amt);
      int n;
      n = eff_n(op, amt);
      return (n == 0) ? 1 : (n + 3) / 4;
   endfunction

   // Called at a negedge while idle; returns at the negedge after the accepting edge.
   task automatic issue(input string name, input logic [2:0] op, input logic [31:0] opd,
                        input logic [31:0] amt);
      start_i   = 1'b1;
      op_i      = op;
      operand_i = opd;
      amount_i  = amt;
      @(negedge clock_i);
      start_i = 1'b0;
      check({name, " busy after start"}, {31'd0, busy_o}, 32'd1);
   endtask

   // Waits for done (bounded), scrambling inputs meanwhile; poke>0 pulses start at that cycle.
   task automatic wait_done(input string name, input logic [31:0] exp, input int lat,
                            input int poke);
      logic [31:0] held;
      int k;
      int bad_hold;
      held     = result_o;
      bad_hold = 0;
      k        = 0;
      while (k < 40) begin
         @(negedge clock_i);
         k++;
         if (done_o) break;
         if (result_o !== held || busy_o !== 1'b1) bad_hold++;
         start_i   = (k == poke);
         op_i      = 3'($urandom_range(0, 7));
         operand_i = $urandom;
         amount_i  = $urandom;
      end
      start_i = 1'b0;
      check({name, " latency"}, 32'(k), 32'(lat));
      check({name, " result"}, result_o, exp);
      check({name, " held/busy during run"}, 32'(bad_hold), 32'd0);
      check({name, " busy in done cycle"}, {31'd0, busy_o}, 32'd0);
   endtask

   task automatic idle_check(input string name);
      @(negedge clock_i);
      check({name, " done pulse width"}, {31'd0, done_o}, 32'd0);
      check({name, " idle after done"}, {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      int dpulses;
      logic [2:0]  rop;
      logic [31:0] ropd, ramt;

      vecs[0]  = '{3'd4, 32'h8000_0001, 32'd1,          32'h0000_0003, 1};
      vecs[1]  = '{3'd4, 32'h1234_5678, 32'd36,         32'h2345_6781, 1};
      vecs[2]  = '{3'd3, 32'h1234_5678, 32'd4,          32'h8123_4567, 1};
      vecs[3]  = '{3'd4, 32'h0000_0001, 32'd31,         32'h8000_0000, 8};
      vecs[4]  = '{3'd1, 32'h8000_0000, 32'd40,         32'hFFFF_FFFF, 8};
      vecs[5]  = '{3'd0, 32'hFFFF_FFFF, 32'd33,         32'h0000_0000, 8};
      vecs[6]  = '{3'd2, 32'h0000_000F, 32'd4,          32'h0000_00F0, 1};
      vecs[7]  = '{3'd3, 32'hDEAD_BEEF, 32'd32,         32'hDEAD_BEEF, 1};
      vecs[8]  = '{3'd5, 32'hCAFE_F00D, 32'd7,          32'hCAFE_F00D, 1};
      vecs[9]  = '{3'd0, 32'h8000_0000, 32'd5,          32'h0400_0000, 2};
      vecs[10] = '{3'd1, 32'h4000_0000, 32'd32,         32'h0000_0000, 8};
      vecs[11] = '{3'd2, 32'h0000_0001, 32'hFFFF_FFFF,  32'h0000_0000, 8};

      clear_i   = 1'b0;
      start_i   = 1'b0;
      op_i      = 3'd0;
      operand_i = 32'd0;
      amount_i  = 32'd0;
      repeat (2) @(negedge clock_i);
      check("reset busy", {31'd0, busy_o}, 32'd0);
      check("reset done", {31'd0, done_o}, 32'd0);
      check("reset result", result_o, 32'd0);
      clear_i = 1'b1;
      @(negedge clock_i);

      for (int i = 0; i < 12; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         issue(nm, vecs[i].op, vecs[i].opd, vecs[i].amt);
         wait_done(nm, vecs[i].exp, vecs[i].lat, 0);
         idle_check(nm);
      end

      // start pulsed mid-run is ignored and not queued
      issue("ignore", 3'd4, 32'h0000_0001, 32'd31);
      wait_done("ignore", 32'h8000_0000, 8, 3);
      idle_check("ignore");

      // back-to-back: second start lands in the done cycle
      issue("b2b_a", 3'd3, 32'h1234_5678, 32'd4);
      wait_done("b2b_a", 32'h8123_4567, 1, 0);
      issue("b2b_b", 3'd2, 32'h0000_000F, 32'd8);
      wait_done("b2b_b", 32'h0000_0F00, 2, 0);
      idle_check("b2b_b");

      // clear mid-run aborts at once and leaves no trailing done
      issue("abort", 3'd4, 32'h1234_5678, 32'd20);
      @(negedge clock_i);
      clear_i = 1'b0;
      #1;
      check("abort busy", {31'd0, busy_o}, 32'd0);
      check("abort done", {31'd0, done_o}, 32'd0);
      check("abort result", result_o, 32'd0);
      @(negedge clock_i);
      clear_i = 1'b1;
      dpulses = 0;
      repeat (10) begin
         @(negedge clock_i);
         if (done_o || busy_o) dpulses++;
      end
      check("abort no done after release", 32'(dpulses), 32'd0);

      for (int i = 0; i < 60; i++) begin
         string nm;
         nm   = $sformatf("rand%0d", i);
         rop  = 3'($urandom_range(0, 7));
         ropd = $urandom;
         ramt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
         issue(nm, rop, ropd, ramt);
         wait_done(nm, model(rop, ropd, ramt), model_lat(rop, ramt), 0);
         if (i % 3 != 0) idle_check(nm);
      end
      idle_check("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
